// File: rtl/mcc_pkg.sv
// mcc_pkg: shared types and constants for the MCC command traffic generator.
//   request_t    - controller command encodings
//   tgen_mode_t  - generator address/request pattern
//   tgen_state_t - generator FSM states
//   LFSR tap positions and feedback helper for the 40-bit address LFSR
package mcc_pkg;

  typedef enum logic [2:0] {
    RD_R  = 3'b001,
    WR_R  = 3'b010,
    RDA_R = 3'b101,
    WRA_R = 3'b110
  } request_t;

  typedef enum logic [1:0] {
    MODE_PAIR = 2'd0,
    MODE_INCR = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_RSVD = 2'd3
  } tgen_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } tgen_state_t;

  localparam int unsigned LFSR_TAP0 = 39;
  localparam int unsigned LFSR_TAP1 = 37;
  localparam int unsigned LFSR_TAP2 = 20;
  localparam int unsigned LFSR_TAP3 = 18;

  function automatic logic lfsr_fb(input logic [39:0] a);
    return a[LFSR_TAP0] ^ a[LFSR_TAP1] ^ a[LFSR_TAP2] ^ a[LFSR_TAP3];
  endfunction

endpackage

// File: rtl/mcc_traffic_gen_if.sv
// mcc_traffic_gen_if: controller command bus driven by the traffic generator.
//   cmd_rdy  - command valid this cycle (generator -> controller)
//   log_addr - command logical address   (generator -> controller)
//   request  - command type              (generator -> controller)
//   busy     - controller cannot accept  (controller -> generator)
interface mcc_traffic_gen_if
  import mcc_pkg::*;
#(
  parameter int unsigned ADDR_W = 40
) ();

  logic              cmd_rdy;
  logic [ADDR_W-1:0] log_addr;
  request_t          request;
  logic              busy;

  modport master (output cmd_rdy, output log_addr, output request, input  busy);
  modport slave  (input  cmd_rdy, input  log_addr, input  request, output busy);

endinterface

// File: rtl/mcc_lfsr.sv
// mcc_lfsr: Fibonacci shift-left LFSR holding the generator address.
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset (value -> 0)
//   load_i  - load seed_i (has priority over adv_i)
//   seed_i  - seed value
//   adv_i   - advance one step
//   value_o - current LFSR value
// Feedback uses taps 39/37/20/18, so W must be at least 40.
module mcc_lfsr
  import mcc_pkg::*;
#(
  parameter int unsigned W = 40
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  input  logic         adv_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= '0;
    end else if (load_i) begin
      lfsr_q <= seed_i;
    end else if (adv_i) begin
      lfsr_q <= {lfsr_q[W-2:0], lfsr_fb(lfsr_q[39:0])};
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/mcc_traffic_gen.sv
// mcc_traffic_gen: programmable command-stream generator for the controller
// command input. Issues num_cmds commands separated by gap idle cycles in
// PAIR (WRA/RDA pairs), INCR (fixed request) or LFSR (pseudo-random address)
// mode.
//   CK_t, reset_n        - clock / asynchronous active-low reset
//   start                - begin a run (sampled only when idle)
//   mode, base_addr      - pattern select, first address / LFSR seed
//   num_cmds, gap        - command count, idle cycles between commands
//   req_sel              - request used in INCR mode
//   cmd (master)         - cmd_rdy / log_addr / request out, busy in
//   active, done, issued - run status, end-of-run pulse, issued count
// Optional: define MCC_TGEN_STALL_CNT_EN to add the stall_cnt output
// (ISSUE cycles with busy high, saturating, cleared on start).
module mcc_traffic_gen
  import mcc_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 40,
  parameter int unsigned       CNT_W       = 16,
  parameter int unsigned       GAP_W       = 8,
  parameter logic [ADDR_W-1:0] ADDR_STRIDE = 64,
  parameter logic [ADDR_W-1:0] LFSR_SEED   = 1
) (
  input  logic              CK_t,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_cmds,
  input  logic [GAP_W-1:0]  gap,
  input  request_t          req_sel,
  mcc_traffic_gen_if.master cmd,
  output logic              active,
  output logic              done,
  output logic [CNT_W-1:0]  issued
`ifdef MCC_TGEN_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  tgen_state_t       state_q;
  tgen_mode_t        mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  issued_q;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gcnt_q;
  request_t          req_sel_q;
  logic              phase_q;     // PAIR: 0 = WRA next, 1 = RDA next
  logic              cmd_rdy_q;
  logic [ADDR_W-1:0] log_addr_q;
  request_t          request_q;
  logic              active_q;
  logic              done_q;

  logic              accept;
  logic              issue_fire;
  logic [CNT_W-1:0]  issued_d;
  logic [ADDR_W-1:0] lfsr_val;
  logic [ADDR_W-1:0] lfsr_seed;
  logic [ADDR_W-1:0] cur_addr;
  request_t          cur_req;

  assign accept     = (state_q == ST_IDLE) && start;
  assign issue_fire = (state_q == ST_ISSUE) && !cmd.busy;
  assign issued_d   = issued_q + CNT_W'(1);
  assign lfsr_seed  = (base_addr == '0) ? LFSR_SEED : base_addr;

  mcc_lfsr #(
    .W (ADDR_W)
  ) u_lfsr (
    .clk_i   (CK_t),
    .rst_ni  (reset_n),
    .load_i  (accept),
    .seed_i  (lfsr_seed),
    .adv_i   (issue_fire && (mode_q == MODE_LFSR)),
    .value_o (lfsr_val)
  );

  always_comb begin
    cur_addr = addr_q;
    cur_req  = req_sel_q;
    case (mode_q)
      MODE_PAIR: cur_req = phase_q ? RDA_R : WRA_R;
      MODE_LFSR: begin
        cur_addr = lfsr_val;
        cur_req  = lfsr_val[0] ? WR_R : RD_R;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_PAIR;
      addr_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      gap_q      <= '0;
      gcnt_q     <= '0;
      req_sel_q  <= RD_R;
      phase_q    <= 1'b0;
      cmd_rdy_q  <= 1'b0;
      log_addr_q <= '0;
      request_q  <= RD_R;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_rdy_q <= 1'b0;
          if (start) begin
            mode_q    <= tgen_mode_t'(mode);
            addr_q    <= base_addr;
            num_q     <= num_cmds;
            gap_q     <= gap;
            req_sel_q <= req_sel;
            phase_q   <= 1'b0;
            issued_q  <= '0;
            if (num_cmds != '0) begin
              active_q <= 1'b1;
              state_q  <= ST_ISSUE;
            end else begin
              state_q  <= ST_DONE;
            end
          end
        end
        ST_ISSUE: begin
          if (cmd.busy) begin
            cmd_rdy_q <= 1'b0;
          end else begin
            cmd_rdy_q  <= 1'b1;
            log_addr_q <= cur_addr;
            request_q  <= cur_req;
            issued_q   <= issued_d;
            // PAIR holds the address across WRA/RDA; LFSR steps in mcc_lfsr.
            case (mode_q)
              MODE_PAIR: begin
                phase_q <= ~phase_q;
                if (phase_q) addr_q <= addr_q + ADDR_STRIDE;
              end
              MODE_LFSR: ;
              default:   addr_q <= addr_q + ADDR_STRIDE;
            endcase
            if (issued_d == num_q) begin
              state_q <= ST_DONE;
            end else if (gap_q != '0) begin
              gcnt_q  <= gap_q;
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          cmd_rdy_q <= 1'b0;
          gcnt_q    <= gcnt_q - GAP_W'(1);
          if (gcnt_q == GAP_W'(1)) state_q <= ST_ISSUE;
        end
        ST_DONE: begin
          cmd_rdy_q <= 1'b0;
          done_q    <= 1'b1;
          active_q  <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MCC_TGEN_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((state_q == ST_ISSUE) && cmd.busy && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign cmd.cmd_rdy  = cmd_rdy_q;
  assign cmd.log_addr = log_addr_q;
  assign cmd.request  = request_q;
  assign active       = active_q;
  assign done         = done_q;
  assign issued       = issued_q;

endmodule

// File: doc/mcc_traffic_gen.md
Name: mcc_traffic_gen

Overview:
- Synthesizable, parametrised command-stream generator that drives the controller command input (cmd_rdy / log_addr / request) in place of hand-written directed stimulus.
- Issues a programmed number of requests with a programmable inter-command gap.
- Three modes: write-then-read pairs, incrementing address, LFSR address.
- Sits in front of the top-level command path. It is used by the bench and by on-chip self-test.

Parameters:
ADDR_W, 40, logical address width (log_addr)
CNT_W, 16, width of command count / issued counter
GAP_W, 8, width of inter-command gap
ADDR_STRIDE, 64, address increment for PAIR and INCR modes
LFSR_SEED, 40'h1, seed used when base_addr is zero in LFSR mode

Ports:
CK_t  in  1  controller clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin a run (sampled only in IDLE)
mode  in  2  0=PAIR, 1=INCR, 2=LFSR, 3=reserved (treated as INCR)
base_addr  in  ADDR_W  first address / LFSR seed
num_cmds  in  CNT_W  commands to issue
gap  in  GAP_W  idle cycles between commands
req_sel  in  3  fixed request used in INCR mode (request_t)
busy  in  1  controller cannot accept a command
cmd_rdy  out  1  command valid this cycle
log_addr  out  ADDR_W  command address
request  out  3  command type (request_t)
active  out  1  run in progress
done  out  1  one-cycle pulse at end of run
issued  out  CNT_W  commands issued in current/last run

Behaviour:
- Clock and reset: single clock CK_t; reset_n is asynchronous, active-low.
- Reset values: all outputs are 0, request = RD_R, state = IDLE, internal counters = 0.
- Reset mid-run: immediately returns to IDLE; cmd_rdy drops asynchronously.
- Output timing: all outputs are registered.
- States: IDLE, ISSUE, GAP, DONE.

IDLE:
- start=1, num_cmds!=0: latch mode, base_addr, num_cmds, gap, req_sel; clear issued; active<=1; go to ISSUE.
- start=1, num_cmds==0: go to DONE directly, issuing nothing.
- start is ignored in every other state.

ISSUE:
- busy=1: stall; cmd_rdy<=0; stay in ISSUE.
- busy=0: cmd_rdy<=1, log_addr<=addr_q, request<=req_q, issued++, advance the generator.
- Then, if issued+1==num_cmds, go to DONE.
- Otherwise, if gap==0, stay in ISSUE (back-to-back commands, cmd_rdy held high, new values each cycle).
- Otherwise, go to GAP with gcnt=gap.

GAP:
- cmd_rdy<=0; gcnt decrements every cycle regardless of busy.
- When gcnt==1, go to ISSUE.
- Result: exactly `gap` low cycles between accepted commands when busy stays low.

DONE:
- cmd_rdy<=0, done<=1 for one cycle, active<=0; go to IDLE.
- issued holds its value until the next start.

Generator:
- PAIR: requests alternate WRA_R, RDA_R, starting with WRA_R on base_addr. The address is held across each pair and advances by ADDR_STRIDE after each RDA_R. An odd num_cmds ends on a WRA_R.
- INCR: request=req_sel on every command; address advances by ADDR_STRIDE after every command.
- LFSR: Fibonacci shift-left, feedback = a[39]^a[37]^a[20]^a[18] applied to the low 40 bits. The seed is base_addr, or LFSR_SEED if base_addr==0. request = addr_q[0] ? WR_R : RD_R.
- Address arithmetic is modulo 2^ADDR_W (silent wrap).

Optional Feature:
- Macro: MCC_TGEN_STALL_CNT_EN.
- Defined: adds output stall_cnt (CNT_W). It counts ISSUE cycles with busy=1, is cleared on an accepted start, saturates at all-ones, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- mcc_pkg holds:
  - request_t: RD_R=3'b001, WR_R=3'b010, RDA_R=3'b101, WRA_R=3'b110
  - tgen_mode_t
  - tgen_state_t
  - LFSR tap constants
- Sub-module mcc_lfsr (parametrised width, seed load, advance enable) holds the address LFSR.

Test Plan:
- PAIR, base=40'h17FD5, num=4, gap=10, busy=0 -> WRA_R@17FD5, RDA_R@17FD5, WRA_R@18015, RDA_R@18015; 10 low cycles between cmd_rdy pulses; done pulses once; issued=4.
- INCR, req_sel=RD_R, base=0, num=3, gap=0 -> cmd_rdy high 3 consecutive cycles with addr 0, 64, 128.
- busy held high 5 cycles during ISSUE of the 2nd command -> no cmd_rdy for 5 cycles, command issued the cycle after busy falls; stall_cnt=5 with MCC_TGEN_STALL_CNT_EN.
- LFSR, base=0 -> first addr=40'h1, second=40'h2; num_cmds=0 start -> done pulse next cycle, no cmd_rdy.
- INCR, base=40'hFF_FFFF_FFC0 -> second address wraps to 0.
- reset_n low mid-GAP -> all outputs 0 immediately; a new start after release runs cleanly.
